// File: rtl/bus_pkg.sv
// Bus transfer codes, code-validity helpers and scheduler FSM encoding.
package bus_pkg;

  localparam logic [4:0] SRC_R0      = 5'd0;
  localparam logic [4:0] SRC_R15     = 5'd15;
  localparam logic [4:0] SRC_HI      = 5'd16;
  localparam logic [4:0] SRC_LO      = 5'd17;
  localparam logic [4:0] SRC_ZHI     = 5'd18;
  localparam logic [4:0] SRC_ZLO     = 5'd19;
  localparam logic [4:0] SRC_PC      = 5'd20;
  localparam logic [4:0] SRC_MDR     = 5'd21;
  localparam logic [4:0] SRC_INPORT  = 5'd22;
  localparam logic [4:0] SRC_SIGNEXT = 5'd23;

  localparam logic [4:0] DST_HI  = 5'd16;
  localparam logic [4:0] DST_LO  = 5'd17;
  localparam logic [4:0] DST_PC  = 5'd20;
  localparam logic [4:0] DST_MDR = 5'd21;
  localparam logic [4:0] DST_MAR = 5'd24;
  localparam logic [4:0] DST_Y   = 5'd25;
  localparam logic [4:0] DST_OUT = 5'd26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT_MEM
  } state_t;

  function automatic logic src_valid(input logic [4:0] code);
    return code <= SRC_SIGNEXT;
  endfunction

  // Destinations: r0-r15, hi, lo, pc, mdr, mar, y, outport.
  function automatic logic dst_valid(input logic [4:0] code);
    return (code <= DST_LO) || (code == DST_PC) || (code == DST_MDR) ||
           (code == DST_MAR) || (code == DST_Y) || (code == DST_OUT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts just after the previous winner.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bus_xfer_sched.sv
// Shared-bus transfer scheduler: round-robin grant, source drive, destination
// load, with a bounded wait on memory-ready for MDR sources.
module bus_xfer_sched
  import bus_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] src,
  input  logic [5*NREQ-1:0] dst,
  input  logic              mem_rdy,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [4:0]        bus_sel,
  output logic [31:0]       ld_en,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

  state_t          state_reg, state_next;
  logic [IW-1:0]   last_reg, own_reg, arb_idx;
  logic [4:0]      src_reg, dst_reg;
  logic [7:0]      cnt_reg, cnt_next;
  logic            complete, load, abort, arb_en, arb_any;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req  (req),
    .last (last_reg),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (arb_idx)
  );

  assign arb_en  = !clr && ((state_reg == ST_IDLE) || complete);
  assign arb_any = |gnt;
  assign busy    = (state_reg != ST_IDLE);

  // Transfer datapath outputs; clr suppresses any load or completion.
  always_comb begin
    complete = 1'b0;
    load     = 1'b0;
    abort    = 1'b0;
    bus_sel  = '0;
    cnt_next = cnt_reg;
    case (state_reg)
      ST_DRIVE: begin
        bus_sel = src_reg;
        if (!src_valid(src_reg) || !dst_valid(dst_reg)) begin
          abort    = 1'b1;
          complete = 1'b1;
        end else if (src_reg != SRC_MDR || mem_rdy) begin
          load     = 1'b1;
          complete = 1'b1;
        end else begin
          cnt_next = 8'd1;
        end
      end
      ST_WAIT_MEM: begin
        bus_sel = SRC_MDR;
        if (mem_rdy) begin
          load     = 1'b1;
          complete = 1'b1;
        end else if (cnt_reg == 8'(MEM_TIMEOUT)) begin
          abort    = 1'b1;
          complete = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: ;
    endcase
    if (complete) cnt_next = '0;

    ld_en = '0;
    done  = '0;
    err   = 1'b0;
    if (!clr) begin
      if (load) ld_en[dst_reg] = 1'b1;
      if (complete) done[own_reg] = 1'b1;
      err = abort;
    end else begin
      bus_sel = '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    if ((state_reg == ST_IDLE) || complete)
      state_next = arb_any ? ST_DRIVE : ST_IDLE;
    else if (state_reg == ST_DRIVE)
      state_next = ST_WAIT_MEM;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      last_reg  <= IW'(NREQ - 1);
      own_reg   <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (arb_any) begin
        last_reg <= arb_idx;
        own_reg  <= arb_idx;
        src_reg  <= src[5*arb_idx +: 5];
        dst_reg  <= dst[5*arb_idx +: 5];
      end
    end
  end

endmodule

// File: tb/tb_bus_xfer_sched.sv
// Directed self-checking bench for bus_xfer_sched (NREQ=4, MEM_TIMEOUT=15).
module tb_bus_xfer_sched;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] src, dst;
  logic              mem_rdy;
  logic [NREQ-1:0]   gnt, done;
  logic              err;
  logic [4:0]        bus_sel;
  logic [31:0]       ld_en;
  logic              busy;

  int checks = 0;
  int errors = 0;

  bus_xfer_sched #(.NREQ(NREQ), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .req(req), .src(src), .dst(dst), .mem_rdy(mem_rdy),
    .gnt(gnt), .done(done), .err(err), .bus_sel(bus_sel), .ld_en(ld_en), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are read 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; req = '0; mem_rdy = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; req = '0; src = '0; dst = '0; mem_rdy = 1'b0;
    tick(); tick();
    clr = 1'b0;
    settle();
    checks++;
    if ({gnt, done, err, bus_sel, ld_en, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b bus_sel=%0d ld_en=%h busy=%b, want all 0",
               gnt, done, err, bus_sel, ld_en, busy);
    end
    $display("test_reset: outputs gnt=%b done=%b busy=%b", gnt, done, busy);
  endtask

  task automatic test_single();
    req = 4'b0001; src[4:0] = 5'd5; dst[4:0] = 5'd16;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick(); req = '0; settle();
    checks++;
    if (bus_sel !== 5'd5 || ld_en !== 32'h0001_0000 || done !== 4'b0001 || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_load: bus_sel=%0d ld_en=%h done=%b busy=%b err=%b, want 5 00010000 0001 1 0",
               bus_sel, ld_en, done, busy, err);
    end
    tick(); settle();
    checks++;
    if (busy !== 1'b0 || ld_en !== 32'h0) begin
      errors++; $display("FAIL single_idle: busy=%b ld_en=%h want 0 0", busy, ld_en);
    end
    $display("test_single: src 5 -> dst 16 completed");
  endtask

  task automatic test_back_to_back();
    logic [4:0] srcs [NREQ] = '{5'd1, 5'd16, 5'd22, 5'd23};
    logic [4:0] dsts [NREQ] = '{5'd0, 5'd17, 5'd20, 5'd26};
    int prev;
    do_clr();
    for (int i = 0; i < NREQ; i++) begin
      src[5*i +: 5] = srcs[i];
      dst[5*i +: 5] = dsts[i];
    end
    req = 4'b1111;
    prev = -1;
    for (int c = 0; c < 5; c++) begin
      int e;
      e = c % NREQ;
      settle();
      checks++;
      if (gnt !== 4'(1 << e)) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, gnt, 4'(1 << e));
      end
      if (prev >= 0) begin
        checks++;
        if (ld_en !== (32'd1 << dsts[prev]) || done !== 4'(1 << prev) || bus_sel !== srcs[prev]) begin
          errors++;
          $display("FAIL b2b_load[%0d]: ld_en=%h done=%b bus_sel=%0d want %h %b %0d",
                   c, ld_en, done, bus_sel, 32'd1 << dsts[prev], 4'(1 << prev), srcs[prev]);
        end
      end
      $display("test_back_to_back: cycle %0d gnt=%b ld_en=%h", c, gnt, ld_en);
      prev = e;
      tick();
    end
    req = '0; settle();
    checks++;
    if (ld_en !== 32'h1 || done !== 4'b0001 || gnt !== 4'b0000) begin
      errors++; $display("FAIL b2b_last: ld_en=%h done=%b gnt=%b want 00000001 0001 0000", ld_en, done, gnt);
    end
    tick(); settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_mdr_wait();
    do_clr();
    req = 4'b0001; src[4:0] = 5'd21; dst[4:0] = 5'd24; mem_rdy = 1'b0;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL mdr_gnt: got %b want 0001", gnt); end
    tick(); req = '0;
    for (int c = 1; c <= 4; c++) begin
      mem_rdy = (c == 4);
      settle();
      checks++;
      if (bus_sel !== 5'd21 || ld_en !== ((c == 4) ? 32'h0100_0000 : 32'h0) ||
          done !== ((c == 4) ? 4'b0001 : 4'b0000) || err !== 1'b0) begin
        errors++;
        $display("FAIL mdr_wait[%0d]: bus_sel=%0d ld_en=%h done=%b err=%b", c, bus_sel, ld_en, done, err);
      end
      $display("test_mdr_wait: cycle T+%0d bus_sel=%0d ld_en=%h done=%b", c, bus_sel, ld_en, done);
      tick();
    end
    mem_rdy = 1'b0; settle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mdr_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    do_clr();
    req = 4'b0001; src[4:0] = 5'd21; dst[4:0] = 5'd25; mem_rdy = 1'b0;
    tick(); req = '0;
    for (int c = 1; c <= 16; c++) begin
      settle();
      checks++;
      if (bus_sel !== 5'd21 || ld_en !== 32'h0 || err !== (c == 16) ||
          done !== ((c == 16) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL timeout[%0d]: bus_sel=%0d ld_en=%h err=%b done=%b", c, bus_sel, ld_en, err, done);
      end
      tick();
    end
    settle();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy=%b err=%b want 0 0", busy, err);
    end
    $display("test_timeout: err raised at T+16, no load");
  endtask

  task automatic test_invalid();
    do_clr();
    req = 4'b0011;
    src[4:0] = 5'd27; dst[4:0] = 5'd1;
    src[9:5] = 5'd3;  dst[9:5] = 5'd18;
    settle();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL inv_gnt0: got %b want 0001", gnt); end
    tick(); req = 4'b0010; settle();
    checks++;
    if (err !== 1'b1 || done !== 4'b0001 || ld_en !== 32'h0 || gnt !== 4'b0010 || bus_sel !== 5'd27) begin
      errors++;
      $display("FAIL inv_src: err=%b done=%b ld_en=%h gnt=%b bus_sel=%0d want 1 0001 0 0010 27",
               err, done, ld_en, gnt, bus_sel);
    end
    tick(); req = '0; settle();
    checks++;
    if (err !== 1'b1 || done !== 4'b0010 || ld_en !== 32'h0 || bus_sel !== 5'd3) begin
      errors++;
      $display("FAIL inv_dst: err=%b done=%b ld_en=%h bus_sel=%0d want 1 0010 0 3", err, done, ld_en, bus_sel);
    end
    $display("test_invalid: src 27 and dst 18 both aborted");
    tick();
  endtask

  task automatic test_clr_wait();
    do_clr();
    req = 4'b0001; src[4:0] = 5'd21; dst[4:0] = 5'd5; mem_rdy = 1'b0;
    tick(); req = '0;
    tick(); settle();
    checks++;
    if (bus_sel !== 5'd21 || ld_en !== 32'h0 || busy !== 1'b1) begin
      errors++; $display("FAIL clr_w1: bus_sel=%0d ld_en=%h busy=%b want 21 0 1", bus_sel, ld_en, busy);
    end
    tick();
    req = 4'b0010; clr = 1'b1; mem_rdy = 1'b1; settle();
    checks++;
    if (ld_en !== 32'h0 || done !== 4'b0000 || gnt !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL clr_w2: ld_en=%h done=%b gnt=%b err=%b want all 0", ld_en, done, gnt, err);
    end
    tick();
    clr = 1'b0; mem_rdy = 1'b0; req = '0; settle();
    checks++;
    if ({gnt, done, err, bus_sel, ld_en, busy} !== '0) begin
      errors++;
      $display("FAIL clr_after: gnt=%b done=%b err=%b bus_sel=%0d ld_en=%h busy=%b want all 0",
               gnt, done, err, bus_sel, ld_en, busy);
    end
    req = 4'b0011; settle();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL clr_rearb: gnt=%b want 0001", gnt); end
    $display("test_clr_wait: transfer dropped, requester 0 granted next");
    tick(); req = '0; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mdr_wait();
    test_timeout();
    test_invalid();
    test_clr_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_xfer_sched.md
# bus_xfer_sched

Round-robin scheduler that shares the single 32-bit datapath bus between several requesting micro-sequencers. It arbitrates requests, drives the 5-bit bus-mux select with the winning source code, and pulses a one-hot register load enable for the destination. A transfer whose source is MDR waits for memory-ready, with a bounded timeout. It sits between the control-step sequencers and the bus mux / register-file load lines.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MEM_TIMEOUT`, 15: maximum WAIT_MEM cycles before a transfer is aborted, 1..255.
- `clk` in 1: rising-edge clock.
- `clr` in 1: reset, synchronous, active-high.
- `req` in NREQ: per-requester request, level. Held until `gnt`.
- `src` in 5*NREQ: source code of requester i in bits [5i+4:5i].
- `dst` in 5*NREQ: destination code of requester i, same packing.
- `mem_rdy` in 1: MDR contents valid.
- `gnt` out NREQ: one-hot grant, single-cycle, combinational in the arbitration cycle.
- `done` out NREQ: one-hot completion pulse for the granted requester.
- `err` out 1: pulse; transfer aborted because of an invalid code or a timeout.
- `bus_sel` out 5: select driven to the bus mux.
- `ld_en` out 32: one-hot load enable, indexed by destination code.
- `busy` out 1: high in DRIVE or WAIT_MEM.

## Operation
- Source codes 0–23 are valid: 0–15 r0–r15, 16 hi, 17 lo, 18 zhi, 19 zlo, 20 pc, 21 mdr, 22 inport, 23 signExt. Codes 24–31 are invalid.
- Destination codes that are valid: 0–15, 16 hi, 17 lo, 20 pc, 21 mdr, 24 mar, 25 y, 26 outport. All other destination codes are invalid.
- The FSM has three states: IDLE, DRIVE and WAIT_MEM.
- Arbitration happens in IDLE, and in any DRIVE or WAIT_MEM cycle that completes a transfer.
  - The search starts at index `last+1` mod NREQ.
  - The first index with `req` set wins. `gnt` for that index asserts and its `src`/`dst` are latched.
  - `last` is updated to the winner.
  - On a grant the next state is DRIVE. With no request the next state is IDLE.
- DRIVE:
  - `bus_sel` equals the latched `src`.
  - If either code is invalid: `err` and `done` assert, `ld_en` is 0, and the transfer completes.
  - Else if `src`≠21, or `mem_rdy`=1: `ld_en[dst]` and `done` assert, and the transfer completes.
  - Else (src=21, `mem_rdy`=0): go to WAIT_MEM with the counter set to 1.
- WAIT_MEM:
  - `bus_sel` is held at 21.
  - If `mem_rdy`=1: `ld_en[dst]` and `done` assert, and the transfer completes.
  - Else if count=MEM_TIMEOUT: `err` and `done` assert, with no load, and the transfer completes.
  - Else the counter increments.
- Outside DRIVE and WAIT_MEM, `bus_sel`=0 and `ld_en`=0.
- At most one `ld_en` bit is ever set, and never one for an invalid destination.
- Destination r0 (code 0) is loadable. Any special r0 semantics are outside this block.

## Timing
- Reset values: `gnt`, `done`, `err`, `ld_en`, `bus_sel` and `busy` are all 0. State is IDLE. `last`=NREQ-1, so requester 0 wins first. Counter is 0.
- `clr` asserted in any state: the next cycle is IDLE and the pending transfer is dropped without `ld_en` or `done`. `clr` has priority over `mem_rdy` in the same cycle.
- Latency from `gnt` (cycle T) to the load is T+1 for a non-MDR source.
- Back-to-back throughput is one transfer per cycle: a completing cycle can grant, and the next transfer drives at the following cycle.
- An MDR source with `mem_rdy` first high in WAIT_MEM cycle k loads at T+1+k.
- Timeout: `err` fires at cycle T+1+MEM_TIMEOUT.
- `req` sampled in a non-arbitrating cycle (DRIVE or WAIT_MEM still pending) is ignored. The requester keeps holding it.
- Requester i must not reassert `req` in the cycle after its own `gnt` unless it wants a new transfer. A held `req` is treated as a new request.
- `ld_en`, `done`, `err`, `gnt` and `bus_sel` are combinational from state, latched registers, `req` and `mem_rdy`. The consumer samples them at the next rising edge.

## Structure
- Package `bus_pkg`:
  - source-code localparams (`SRC_R0`..`SRC_SIGNEXT`, `SRC_MDR`=21);
  - destination-code localparams (`DST_MAR`=24, `DST_Y`=25, `DST_OUT`=26);
  - validity functions `src_valid` and `dst_valid`;
  - FSM state encoding.
- Sub-module `rr_arbiter`: parameterised on NREQ. Inputs are `req`, `last` and `en`. Outputs are one-hot `gnt` and the encoded index.
- The top level holds the FSM, latch registers and timeout counter.

## Test plan
- Reset, then `req`=0001, src0=5, dst0=16: `gnt`=0001 at T; at T+1 `bus_sel`=5, `ld_en`=1<<16, `done`=0001; `busy` back to 0 at T+2.
- `req`=1111 held continuously with valid non-MDR codes: grants in order 0,1,2,3,0 on consecutive cycles, one `ld_en` pulse per cycle.
- src=21, `mem_rdy` low for 3 cycles then high: `bus_sel`=21 for 4 cycles, `ld_en` is 0 until the 4th; `done` and `ld_en[dst]` assert in that cycle.
- src=21 with `mem_rdy` stuck low, MEM_TIMEOUT=15: `err` and `done` at T+16, `ld_en` never set.
- src=27 or dst=18: at T+1 `err`=1, `done`=1, `ld_en`=0; the next requester is granted in the same cycle.
- `clr` asserted in the 2nd WAIT_MEM cycle, with `mem_rdy` high in that same cycle: no `ld_en` and no `done`; all outputs are at reset values the next cycle; requester 0 wins the next arbitration.
